dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port synchronous data memory between the processor load/store port and a debug/loader port. The debug port is used by bench and bring-up logic to preload and dump DMEM without reaching into memory internals. The arbiter sits between `processor_0`/debug master and `dmem_0` inside `SoC`. It provides round-robin arbitration, a debug exclusive lock, out-of-range error responses and a saturating conflict counter.

## Interface
- `DMEM_SIZE_IN_BYTES`, 1024: memory size; word index width `AW = log2(DMEM_SIZE_IN_BYTES/4)`.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `p_req`, `p_we`  in  1  processor request, write enable.
- `p_addr`  in  32  processor byte address; `[1:0]` ignored.
- `p_wdata`  in  32  processor write data.
- `p_wstrb`  in  4  processor byte strobes.
- `p_gnt`  out  1  processor request accepted this cycle.
- `p_rvalid`, `p_err`  out  1  processor response valid, response error.
- `p_rdata`  out  32  processor response data.
- `d_req`, `d_we`, `d_addr`, `d_wdata`, `d_wstrb`, `d_gnt`, `d_rvalid`, `d_err`, `d_rdata`: debug port; same widths and meaning as the `p_*` port.
- `d_lock`  in  1  debug requests exclusive ownership.
- `d_locked`  out  1  exclusive ownership is active.
- `m_en`  out  1  memory access enable.
- `m_we`  out  4  memory byte write enables.
- `m_addr`  out  AW  memory word index.
- `m_wdata`  out  32  memory write data.
- `m_rdata`  in  32  memory read data, valid one cycle after `m_en`.
- `conflicts`  out  16  saturating count of cycles where both `p_req` and `d_req` were high and one port was refused.

## Operation
- FSM states are ARB and LOCK. Reset state is ARB.
- In ARB:
  - A single request is granted.
  - If both ports request, grant the port not granted most recently, using the `last` register. After reset `last` = debug, so the processor wins the first tie.
  - If `d_lock`=1 in ARB, the processor is not granted that cycle and the next state is LOCK.
- In LOCK:
  - Only the debug port is granted; `p_gnt`=0.
  - `d_locked`=1.
  - If `d_lock`=0, the next state is ARB and `last` is set to debug.
- Requester hold rule: a requester holds `req` and all its fields stable until it sees `gnt`. The arbiter never grants a port whose `req`=0.
- Granted in-range access (`addr < DMEM_SIZE_IN_BYTES`):
  - `m_en`=1, `m_addr`=`addr[AW+1:2]`.
  - `m_we` = `wstrb` when `we`=1, otherwise 0.
  - `m_wdata` = `wdata`.
- Granted out-of-range access:
  - `m_en`=0 and memory is untouched.
  - The response is `err`=1, `rdata`=0.
- Writes with `wstrb`=0 drive `m_en`=1, `m_we`=0 and are acknowledged normally.
- Response routing:
  - A 1-bit owner register plus a pending flag records the granted port.
  - Next cycle, that port's `rvalid`=1 for both reads and writes.
  - `rdata` = `m_rdata` for reads and 0 for writes or errors.
  - The other port's `rvalid`=0.
- `rdata` of each port holds its last value when `rvalid`=0.
- `conflicts` increments by 1 per conflict cycle, saturating at 16'hFFFF. A cycle in LOCK with `p_req`=1 counts as a conflict only if `d_req`=1.

## Timing
- `gnt` and the `m_*` signals are combinational from request inputs and registered state, in the same cycle. At most one `gnt` is high per cycle.
- Response latency is exactly 1 cycle after `gnt`. Back-to-back grants every cycle are supported, giving a throughput of 1 access per cycle.
- Lock entry: `d_lock` rising blocks `p_gnt` in the same cycle. `d_locked` rises the following cycle.
- Lock exit: processor grants become possible the cycle after `d_lock` is seen low in LOCK.
- While reset=1, outputs are forced as follows:
  - `p_gnt`, `d_gnt`, `m_en`, `m_we` are 0.
- On the clock edge with reset=1:
  - `p_rvalid`, `d_rvalid`, `p_err`, `d_err` are 0.
  - `p_rdata` and `d_rdata` are 0.
  - `d_locked`=0, `conflicts`=0, state=ARB, `last`=debug, pending=0.
- Reset mid-operation: a response pending at the reset edge is dropped and `rvalid` is never asserted for it.

## Test plan
- Processor writes 32'hDEADBEEF to 0x10 with `wstrb`=4'hF, then reads 0x10. Required: `p_gnt` the same cycle; `p_rvalid` one cycle later; read `p_rdata`=32'hDEADBEEF, `p_err`=0.
- Both ports request reads on 4 consecutive cycles with fields held. Required grants alternate P,D,P,D starting with P after reset; `conflicts`=4.
- Debug holds `d_lock`=1 for 3 cycles while `p_req`=1 continuously. Required: `p_gnt`=0 throughout; `d_locked`=1 from cycle 2; processor granted on the cycle after `d_lock`=0 is seen.
- Debug writes byte 8'hA5 to 0x20 with `wstrb`=4'b0010 over existing 32'h00000000. Required: a readback of 32'h0000A500.
- Processor reads 0x400 with size 1024. Required: `m_en`=0, `p_rvalid`=1 next cycle with `p_err`=1, `p_rdata`=0.
- Reset is asserted the cycle after a debug read is granted. Required: `d_rvalid` is never asserted for that read, and all outputs take their reset values.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one single-port DMEM between processor and debug ports
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   p_req/p_we/p_addr/p_wdata/p_wstrb  processor request (held until p_gnt)
//   p_gnt, p_rvalid, p_err, p_rdata    processor grant and one-cycle-later response
//   d_*                             debug/loader port, same meaning as p_*
//   d_lock, d_locked                debug exclusive-ownership request / active indication
//   m_en/m_we/m_addr/m_wdata/m_rdata   single-port synchronous memory (rdata one cycle after m_en)
//   conflicts                       saturating count of cycles with both ports requesting
module dmem_arbiter #(
    parameter int DMEM_SIZE_IN_BYTES = 1024,
    localparam int AW = $clog2(DMEM_SIZE_IN_BYTES / 4)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p_req,
    input  logic          p_we,
    input  logic [31:0]   p_addr,
    input  logic [31:0]   p_wdata,
    input  logic [3:0]    p_wstrb,
    output logic          p_gnt,
    output logic          p_rvalid,
    output logic          p_err,
    output logic [31:0]   p_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_wstrb,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic          d_err,
    output logic [31:0]   d_rdata,
    input  logic          d_lock,
    output logic          d_locked,
    output logic          m_en,
    output logic [3:0]    m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata,
    output logic [15:0]   conflicts
);

    typedef enum logic {ARB, LOCK} state_t;

    state_t      state;
    state_t      state_next;
    logic        last_dbg;   // 1: debug was granted most recently
    logic        pending;    // a response is due this cycle
    logic        owner_dbg;  // port owning the pending response
    logic        pend_err;
    logic        pend_rd;
    logic [31:0] p_hold;
    logic [31:0] d_hold;

    logic        any_gnt;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic        in_range;
    logic [31:0] resp_data;

    always_comb begin
        state_next = state;
        p_gnt      = 1'b0;
        d_gnt      = 1'b0;
        case (state)
            ARB: begin
                if (d_lock) begin
                    // lock request blocks the processor in the same cycle
                    d_gnt      = d_req;
                    state_next = LOCK;
                end else if (p_req && d_req) begin
                    if (last_dbg) p_gnt = 1'b1;
                    else          d_gnt = 1'b1;
                end else begin
                    p_gnt = p_req;
                    d_gnt = d_req;
                end
            end
            LOCK: begin
                d_gnt = d_req;
                if (!d_lock) state_next = ARB;
            end
            default: state_next = ARB;
        endcase
        if (reset) begin
            p_gnt = 1'b0;
            d_gnt = 1'b0;
        end
    end

    assign any_gnt   = p_gnt | d_gnt;
    assign sel_we    = d_gnt ? d_we    : p_we;
    assign sel_addr  = d_gnt ? d_addr  : p_addr;
    assign sel_wdata = d_gnt ? d_wdata : p_wdata;
    assign sel_wstrb = d_gnt ? d_wstrb : p_wstrb;
    assign in_range  = sel_addr < 32'(DMEM_SIZE_IN_BYTES);

    assign m_en    = any_gnt & in_range;
    assign m_we    = (m_en && sel_we) ? sel_wstrb : 4'b0000;
    assign m_addr  = sel_addr[AW+1:2];
    assign m_wdata = sel_wdata;

    // Responses are masked while reset is high so a grant made just before
    // reset never produces a visible rvalid.
    assign p_rvalid  = pending & ~owner_dbg & ~reset;
    assign d_rvalid  = pending &  owner_dbg & ~reset;
    assign p_err     = p_rvalid & pend_err;
    assign d_err     = d_rvalid & pend_err;
    assign resp_data = (pend_err || !pend_rd) ? 32'h0 : m_rdata;
    assign p_rdata   = p_rvalid ? resp_data : p_hold;
    assign d_rdata   = d_rvalid ? resp_data : d_hold;
    assign d_locked  = (state == LOCK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB;
            last_dbg  <= 1'b1;
            pending   <= 1'b0;
            owner_dbg <= 1'b0;
            pend_err  <= 1'b0;
            pend_rd   <= 1'b0;
            p_hold    <= 32'h0;
            d_hold    <= 32'h0;
            conflicts <= 16'h0;
        end else begin
            state     <= state_next;
            pending   <= any_gnt;
            owner_dbg <= d_gnt;
            pend_err  <= any_gnt & ~in_range;
            pend_rd   <= ~sel_we;
            if (any_gnt) last_dbg <= d_gnt;
            if (state == LOCK && !d_lock) last_dbg <= 1'b1;
            if (p_rvalid) p_hold <= resp_data;
            if (d_rvalid) d_hold <= resp_data;
            // with both requesting, at most one grant means one is refused
            if (p_req && d_req && conflicts != 16'hFFFF) conflicts <= conflicts + 16'd1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with behavioural model and memory
module tb_dmem_arbiter;

    localparam int SIZE = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p_req = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = 32'h0, p_wdata = 32'h0;
    logic [3:0]  p_wstrb = 4'h0;
    logic        p_gnt, p_rvalid, p_err;
    logic [31:0] p_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = 32'h0, d_wdata = 32'h0;
    logic [3:0]  d_wstrb = 4'h0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        d_lock = 1'b0;
    logic        d_locked;
    logic        m_en;
    logic [3:0]  m_we;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = 32'h0;
    logic [15:0] conflicts;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DMEM_SIZE_IN_BYTES(SIZE)) dut (
        .clk(clk), .reset(reset),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_wstrb(p_wstrb),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_err(p_err), .p_rdata(p_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
        .d_lock(d_lock), .d_locked(d_locked),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .conflicts(conflicts)
    );

    // memory seen by the DUT
    logic [31:0] mem [256] = '{default: 32'h0};
    always @(posedge clk) begin
        if (m_en) begin
            m_rdata <= mem[m_addr];
            for (int b = 0; b < 4; b++)
                if (m_we[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: contents, lock flag, round-robin memory, pending response
    logic [31:0] ref_mem [256] = '{default: 32'h0};
    bit          live = 1'b0;
    bit          e_locked, e_last_dbg;
    logic [15:0] e_conf;
    bit          r_valid, r_dbg, r_err;
    logic [31:0] r_data, e_phold, e_dhold;
    bit          eg_p, eg_d, vp, vd, inr, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;

    always @(negedge clk) begin
        if (reset) begin
            eg_p = 1'b0;
            eg_d = 1'b0;
        end else if (e_locked || d_lock) begin
            eg_p = 1'b0;
            eg_d = d_req;
        end else if (p_req && d_req) begin
            eg_p = e_last_dbg;
            eg_d = !e_last_dbg;
        end else begin
            eg_p = p_req;
            eg_d = d_req;
        end
        s_we    = eg_d ? d_we    : p_we;
        s_addr  = eg_d ? d_addr  : p_addr;
        s_wdata = eg_d ? d_wdata : p_wdata;
        s_wstrb = eg_d ? d_wstrb : p_wstrb;
        inr     = s_addr < SIZE;
        vp = !reset && r_valid && !r_dbg;
        vd = !reset && r_valid && r_dbg;

        if (live) begin
            chk("p_rvalid", 32'(p_rvalid), 32'(vp));
            chk("d_rvalid", 32'(d_rvalid), 32'(vd));
            chk("p_err", 32'(p_err), 32'(vp && r_err));
            chk("d_err", 32'(d_err), 32'(vd && r_err));
            chk("p_rdata", p_rdata, vp ? r_data : e_phold);
            chk("d_rdata", d_rdata, vd ? r_data : e_dhold);
            chk("d_locked", 32'(d_locked), 32'(e_locked));
            chk("conflicts", 32'(conflicts), 32'(e_conf));
            chk("p_gnt", 32'(p_gnt), 32'(eg_p));
            chk("d_gnt", 32'(d_gnt), 32'(eg_d));
            chk("m_en", 32'(m_en), 32'((eg_p || eg_d) && inr));
            chk("m_we", 32'(m_we), ((eg_p || eg_d) && inr && s_we) ? 32'(s_wstrb) : 32'h0);
            if ((eg_p || eg_d) && inr) begin
                chk("m_addr", 32'(m_addr), 32'(s_addr[9:2]));
                chk("m_wdata", m_wdata, s_wdata);
            end
        end

        if (reset) begin
            live       = 1'b1;
            e_locked   = 1'b0;
            e_last_dbg = 1'b1;
            e_conf     = 16'h0;
            r_valid    = 1'b0;
            r_dbg      = 1'b0;
            r_err      = 1'b0;
            r_data     = 32'h0;
            e_phold    = 32'h0;
            e_dhold    = 32'h0;
        end else if (live) begin
            if (vp) e_phold = r_data;
            if (vd) e_dhold = r_data;
            r_valid = eg_p || eg_d;
            if (r_valid) begin
                r_dbg  = eg_d;
                r_err  = !inr;
                r_data = (!inr || s_we) ? 32'h0 : ref_mem[s_addr[9:2]];
                if (inr && s_we)
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) ref_mem[s_addr[9:2]][8*b +: 8] = s_wdata[8*b +: 8];
                e_last_dbg = eg_d;
            end
            if (e_locked && !d_lock) e_last_dbg = 1'b1;
            e_locked = d_lock;
            if (p_req && d_req && e_conf != 16'hFFFF) e_conf = e_conf + 16'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_req = 1'b0; p_we = 1'b0; p_addr = 32'h0; p_wdata = 32'h0; p_wstrb = 4'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
        d_lock = 1'b0;
    endtask

    task automatic set_p(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws);
        p_req = 1'b1; p_we = we; p_addr = addr; p_wdata = wd; p_wstrb = ws;
    endtask

    task automatic set_d(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; d_wstrb = ws;
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(19);
        if (r == 0) return $urandom | 32'h400;
        if (r == 1) return 32'h3FC;
        return (32'($urandom_range(31)) << 2) | 32'($urandom_range(3));
    endfunction

    logic pg, dg;

    initial begin
        idle();
        reset = 1'b1;
        p_req = 1'b1;
        step();
        #3;
        chk("rst_p_gnt", 32'(p_gnt), 32'h0);
        chk("rst_m_en", 32'(m_en), 32'h0);
        chk("rst_conflicts", 32'(conflicts), 32'h0);
        chk("rst_d_locked", 32'(d_locked), 32'h0);
        step();
        reset = 1'b0;
        idle();

        // processor write then read
        set_p(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        #3;
        chk("t1_wr_gnt", 32'(p_gnt), 32'h1);
        chk("t1_wr_m_we", 32'(m_we), 32'hF);
        chk("t1_wr_m_addr", 32'(m_addr), 32'h4);
        step();
        set_p(1'b0, 32'h10, 32'h0, 4'h0);
        #3;
        chk("t1_wr_rvalid", 32'(p_rvalid), 32'h1);
        chk("t1_rd_gnt", 32'(p_gnt), 32'h1);
        step();
        p_req = 1'b0;
        #3;
        chk("t1_rd_rvalid", 32'(p_rvalid), 32'h1);
        chk("t1_rd_rdata", p_rdata, 32'hDEADBEEF);
        chk("t1_rd_err", 32'(p_err), 32'h0);

        // tie alternation after reset
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_p(1'b0, 32'h10, 32'h0, 4'h0);
        set_d(1'b0, 32'h20, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("t2_p_gnt", 32'(p_gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("t2_d_gnt", 32'(d_gnt), (i % 2 == 1) ? 32'h1 : 32'h0);
            step();
        end
        idle();
        #3;
        chk("t2_conflicts", 32'(conflicts), 32'h4);

        // debug lock for three cycles with processor requesting
        step();
        set_p(1'b0, 32'h10, 32'h0, 4'h0);
        d_lock = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #3;
            chk("t3_p_gnt_locked", 32'(p_gnt), 32'h0);
            chk("t3_d_locked", 32'(d_locked), (c >= 2) ? 32'h1 : 32'h0);
            step();
        end
        d_lock = 1'b0;
        #3;
        chk("t3_p_gnt_exit", 32'(p_gnt), 32'h0);
        chk("t3_d_locked_exit", 32'(d_locked), 32'h1);
        step();
        #3;
        chk("t3_p_gnt_after", 32'(p_gnt), 32'h1);
        chk("t3_d_locked_after", 32'(d_locked), 32'h0);
        chk("t3_conflicts", 32'(conflicts), 32'h4);
        step();
        p_req = 1'b0;

        // debug byte-lane write then readback
        set_d(1'b1, 32'h20, 32'hFFFFA5FF, 4'b0010);
        #3;
        chk("t4_d_gnt", 32'(d_gnt), 32'h1);
        chk("t4_m_we", 32'(m_we), 32'h2);
        step();
        set_d(1'b0, 32'h20, 32'h0, 4'h0);
        step();
        d_req = 1'b0;
        #3;
        chk("t4_rvalid", 32'(d_rvalid), 32'h1);
        chk("t4_rdata", d_rdata, 32'h0000A500);

        // out-of-range processor read
        step();
        set_p(1'b0, 32'h400, 32'h0, 4'h0);
        #3;
        chk("t5_p_gnt", 32'(p_gnt), 32'h1);
        chk("t5_m_en", 32'(m_en), 32'h0);
        step();
        p_req = 1'b0;
        #3;
        chk("t5_rvalid", 32'(p_rvalid), 32'h1);
        chk("t5_err", 32'(p_err), 32'h1);
        chk("t5_rdata", p_rdata, 32'h0);

        // reset the cycle after a locked debug read is granted
        step();
        set_d(1'b0, 32'h10, 32'h0, 4'h0);
        d_lock = 1'b1;
        #3;
        chk("t6_d_gnt", 32'(d_gnt), 32'h1);
        step();
        reset = 1'b1;
        idle();
        #3;
        chk("t6_rvalid_in_reset", 32'(d_rvalid), 32'h0);
        chk("t6_m_en_in_reset", 32'(m_en), 32'h0);
        step();
        reset = 1'b0;
        #3;
        chk("t6_rvalid_after", 32'(d_rvalid), 32'h0);
        chk("t6_d_rdata", d_rdata, 32'h0);
        chk("t6_d_locked", 32'(d_locked), 32'h0);
        chk("t6_conflicts", 32'(conflicts), 32'h0);

        // randomized traffic obeying the hold rule
        for (int cyc = 0; cyc < 4000; cyc++) begin
            pg = p_gnt;
            dg = d_gnt;
            step();
            if (!p_req || pg) begin
                if ($urandom_range(9) < 6) set_p(1'($urandom_range(1)), rnd_addr(), $urandom, 4'($urandom_range(15)));
                else p_req = 1'b0;
            end
            if (!d_req || dg) begin
                if ($urandom_range(9) < 6) set_d(1'($urandom_range(1)), rnd_addr(), $urandom, 4'($urandom_range(15)));
                else d_req = 1'b0;
            end
            if ($urandom_range(15) == 0) d_lock = !d_lock;
            reset = ($urandom_range(299) == 0);
            #3;
        end

        reset = 1'b0;
        idle();
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
